// File: rtl/lfsr_xor_byte_cipher.sv
// lfsr_xor_byte_cipher: packs the LFSR keystream (1 bit/clk, first bit in the MSB) into bytes,
//   buffers them in a small FIFO and XORs one buffered byte onto each accepted data byte.
// Latency: 1 clk from accepted input (in_valid && in_ready) to out_valid.
// Backpressure: out_valid/out_data hold while !out_ready. in_ready drops when the output
//   register is blocked or no keystream byte is buffered. The packer never stalls, so a
//   keystream byte that finds the FIFO full is dropped and ks_overrun latches.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset, shared with the LFSR
//   ks_bit            keystream bit from the LFSR, sampled every posedge while rst is low
//   in_data/_valid    input byte (plaintext or ciphertext), with valid
//   in_ready          combinational: a keystream byte is buffered and the output can take a byte
//   out_data/_valid   registered result in_data ^ keystream byte, with valid
//   out_ready         sink accepts out_data
//   ks_level          number of buffered keystream bytes (0..KS_DEPTH)
//   ks_overrun        sticky until rst: a keystream byte was dropped, so sync with the far end is lost
//   byte_cnt          completed output transfers, wraps (present only with BYTE_CNT_EN)
//
// Build option: define BYTE_CNT_EN to add the byte_cnt port and its counter.

module lfsr_xor_byte_cipher #(
    parameter int KS_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ks_bit,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(KS_DEPTH):0]   ks_level,
    output logic                        ks_overrun
`ifdef BYTE_CNT_EN
    ,
    output logic [CNT_W-1:0]            byte_cnt
`endif
);

    localparam int PTR_W = $clog2(KS_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(KS_DEPTH);

    // Pointer wrap-around relies on the depth being an exact power of two.
    if (KS_DEPTH < 2 || (KS_DEPTH & (KS_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("lfsr_xor_byte_cipher: KS_DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Only 7 bits of history are needed: on the 8th bit the byte is
    // {sr_q, ks_bit} and goes straight into the FIFO.
    logic [6:0]       sr_q,       sr_d;
    logic [2:0]       bitcnt_q,   bitcnt_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0] level_q,    level_d;
    logic             overrun_q,  overrun_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_vld_q,  out_vld_d;

    logic [7:0]       mem_q [KS_DEPTH];

    // ------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------
    logic       byte_done;
    logic [7:0] push_byte;
    logic       fifo_full;
    logic       fifo_empty;
    logic       in_fire;
    logic       out_fire;
    logic       push;
    logic [7:0] head_byte;

    assign byte_done  = (bitcnt_q == 3'd7);
    assign push_byte  = {sr_q, ks_bit};
    assign fifo_full  = (level_q == FULL_LVL);
    assign fifo_empty = (level_q == '0);
    assign head_byte  = mem_q[rd_ptr_q];

    // in_ready deliberately ignores in_valid so a source may wait for it.
    // While rst is high level_q is already forced to zero, so in_ready is low.
    assign in_ready = !fifo_empty && (!out_vld_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_vld_q && out_ready;

    // A pop in the same cycle frees the slot the new byte needs, so a full
    // FIFO still accepts the push. The write lands on the slot being read,
    // which is fine: the read uses the pre-edge contents.
    assign push = byte_done && (!fifo_full || in_fire);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sr_d       = {sr_q[5:0], ks_bit};
        bitcnt_d   = bitcnt_q + 3'd1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overrun_d  = overrun_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (byte_done && !push) begin
            overrun_d = 1'b1;
        end

        if (in_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, in_fire})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new transfer takes priority over draining so the output can
        // run at one byte per clock when the sink keeps up.
        if (in_fire) begin
            out_data_d = in_data ^ head_byte;
            out_vld_d  = 1'b1;
        end else if (out_fire) begin
            out_vld_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q       <= '0;
            bitcnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            bitcnt_q   <= bitcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overrun_q  <= overrun_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // Storage needs no reset: level_q and the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_vld_q;
    assign ks_level   = level_q;
    assign ks_overrun = overrun_q;

`ifdef BYTE_CNT_EN
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (out_fire) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_xor_byte_cipher.sv
// Bench for lfsr_xor_byte_cipher: drives it from a keyed 8-bit Galois LFSR
// (x^8+x^6+x^5+x^4+1, output = state MSB) reset together with the DUT.
// Expected output bytes are queued at each accepted input and compared as the
// DUT completes output transfers.

module tb_lfsr_xor_byte_cipher;

    localparam int KS_DEPTH = 4;
    localparam int CNT_W    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ks_bit;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] ks_level;
    logic       ks_overrun;
`ifdef BYTE_CNT_EN
    logic [CNT_W-1:0] byte_cnt;
`endif

    lfsr_xor_byte_cipher #(.KS_DEPTH(KS_DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ks_bit     (ks_bit),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ks_level   (ks_level),
        .ks_overrun (ks_overrun)
`ifdef BYTE_CNT_EN
        ,
        .byte_cnt   (byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Keystream source
    logic [7:0] key = 8'h00;
    logic [7:0] lfsr_q;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= key;
        else     lfsr_q <= {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h71 : 8'h00);
    end
    assign ks_bit = lfsr_q[7];

    // Reference keystream byte idx for a given key (first bit in the MSB).
    function automatic logic [7:0] ks_ref(input logic [7:0] k, input int idx);
        logic [7:0] s;
        logic [7:0] b;
        s = k;
        b = 8'h00;
        for (int i = 0; i < 8 * idx + 8; i++) begin
            if (i >= 8 * idx) b = {b[6:0], s[7]};
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
        end
        return b;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int ks_idx = 0;

    // Scoreboard feed: handshakes are sampled mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data ^ ks_ref(key, ks_idx));
                ks_idx++;
            end
            if (out_valid && out_ready) act_q.push_back(out_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for two clocks, then release just after a posedge.
    task automatic do_reset(input logic [7:0] k);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        key       = k;
        rst       = 1'b1;
        tick(2);
        exp_q.delete();
        act_q.delete();
        ks_idx = 0;
        rst    = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 64) begin
            tick(1);
            n++;
        end
    endtask

    // Offer one byte and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input string name);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        wait_ready(n);
        n_checks++;
        if (n >= 64) begin
            n_fail++;
            $display("FAIL %s_timeout: in_ready never rose (waited %0d clks, need < 64)", name, n);
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b1;
        tick(2);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL rst_ks_level: got %0d want 0", ks_level); end
        n_checks++; if (ks_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", ks_overrun); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
`ifdef BYTE_CNT_EN
        n_checks++; if (byte_cnt !== '0) begin n_fail++; $display("FAIL rst_byte_cnt: got %0d want 0", byte_cnt); end
`endif
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_identity();
        logic [7:0] vals [4];
        logic [7:0] a, e;
        vals[0] = 8'h12; vals[1] = 8'h34; vals[2] = 8'h56; vals[3] = 8'h78;
        do_reset(8'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(vals[i], "ident");
        tick(2);
        n_checks++; if (act_q.size() != 4) begin n_fail++; $display("FAIL ident_count: got %0d outputs want 4", act_q.size()); end
        for (int i = 0; i < 4 && act_q.size() > 0; i++) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (a !== e) begin n_fail++; $display("FAIL ident_sb[%0d]: got %h want %h", i, a, e); end
            n_checks++; if (a !== vals[i]) begin n_fail++; $display("FAIL ident_plain[%0d]: got %h want %h", i, a, vals[i]); end
        end
`ifdef BYTE_CNT_EN
        n_checks++; if (byte_cnt !== 16'd4) begin n_fail++; $display("FAIL ident_byte_cnt: got %0d want 4", byte_cnt); end
`endif
    endtask

    task automatic test_keystream();
        int n;
        logic [7:0] a, e;
        do_reset(8'h80);
        wait_ready(n);
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL ks_ready_rise: got %0d clks want 8", n); end
        out_ready = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        tick(1);
        in_valid  = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1)
            begin n_fail++; $display("FAIL ks_first_00: got v=%b d=%h want v=1 d=b1", out_valid, out_data); end
        send_byte(8'h00, "ks2");
        tick(2);
        n_checks++; if (act_q.size() != 2) begin n_fail++; $display("FAIL ks_count: got %0d outputs want 2", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (a !== e) begin n_fail++; $display("FAIL ks_sb: got %h want %h", a, e); end
        end
        do_reset(8'h80);
        send_byte(8'hFF, "ks_ff");
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h4E)
            begin n_fail++; $display("FAIL ks_first_ff: got v=%b d=%h want v=1 d=4e", out_valid, out_data); end
    endtask

    task automatic test_backpressure();
        int bad;
        logic [7:0] a, e;
        do_reset(8'h80);
        out_ready = 1'b0;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        bad = 0;
        for (int i = 1; i <= 44; i++) begin
            tick(1);
            if (i >= 9 && (out_valid !== 1'b1 || out_data !== 8'hEB || in_ready !== 1'b0)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable clks want 0 (v=%b d=%h rdy=%b)", bad, out_valid, out_data, in_ready); end
        n_checks++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL bp_accepts: got %0d want 1", exp_q.size()); end
        n_checks++; if (ks_level !== 3'(KS_DEPTH)) begin n_fail++; $display("FAIL bp_level: got %0d want %0d", ks_level, KS_DEPTH); end
        n_checks++; if (ks_overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun: got %b want 0", ks_overrun); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(1);
        n_checks++; if (act_q.size() != 1) begin n_fail++; $display("FAIL bp_drain: got %0d outputs want 1", act_q.size()); end
        if (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (a !== e) begin n_fail++; $display("FAIL bp_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_overrun();
        do_reset(8'h80);
        tick(39);
        n_checks++; if (ks_overrun !== 1'b0 || ks_level !== 3'd4)
            begin n_fail++; $display("FAIL ovr_before: got ovr=%b lvl=%0d want ovr=0 lvl=4", ks_overrun, ks_level); end
        tick(1);
        n_checks++; if (ks_overrun !== 1'b1 || ks_level !== 3'd4)
            begin n_fail++; $display("FAIL ovr_set: got ovr=%b lvl=%0d want ovr=1 lvl=4", ks_overrun, ks_level); end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick(10);
        n_checks++; if (ks_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ks_overrun); end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ks_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ks_overrun); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, e;
        do_reset(8'h80);
        out_ready = 1'b1;
        tick(39);
        n_checks++; if (ks_level !== 3'd4) begin n_fail++; $display("FAIL b2b_prefill: got %0d want 4", ks_level); end
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick(1);
        n_checks++; if (ks_level !== 3'd4 || ks_overrun !== 1'b0)
            begin n_fail++; $display("FAIL b2b_full_pushpop: got lvl=%0d ovr=%b want lvl=4 ovr=0", ks_level, ks_overrun); end
        for (int i = 1; i <= 12; i++) begin
            in_data = 8'(i * 37);
            tick(1);
            if (i == 4) begin
                n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL b2b_drain_level: got %0d want 0", ks_level); end
            end
        end
        in_valid = 1'b0;
        tick(2);
        n_checks++; if (act_q.size() != 6) begin n_fail++; $display("FAIL b2b_count: got %0d outputs want 6", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (a !== e) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", a, e); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, e;
        do_reset(8'h80);
        out_ready = 1'b1;
        send_byte(8'h00, "mid1");
        send_byte(8'h11, "mid2");
        tick(1);
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (a !== e) begin n_fail++; $display("FAIL mid_sb: got %h want %h", a, e); end
        end
        out_ready = 1'b0;
        send_byte(8'h22, "mid3");
        tick(2);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ks_level !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00)
            begin n_fail++; $display("FAIL mid_async_clear: got lvl=%0d v=%b d=%h want 0/0/00", ks_level, out_valid, out_data); end
`ifdef BYTE_CNT_EN
        n_checks++; if (byte_cnt !== '0) begin n_fail++; $display("FAIL mid_byte_cnt_rst: got %0d want 0", byte_cnt); end
`endif
        do_reset(8'h80);
        out_ready = 1'b1;
        send_byte(8'h00, "mid_after");
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1)
            begin n_fail++; $display("FAIL mid_restart: got v=%b d=%h want v=1 d=b1", out_valid, out_data); end
        tick(1);
`ifdef BYTE_CNT_EN
        n_checks++; if (byte_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_byte_cnt_one: got %0d want 1", byte_cnt); end
`endif
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drained: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_keystream();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1000000 time units");
        $fatal(1, "watchdog");
    end

endmodule
